// File: rtl/riscv_mc_sequencer.sv
// riscv_mc_sequencer: multi-cycle RV32I control sequencer.
// Steps FETCH/DECODE/EXEC/MEM/WB, owns the shared memory handshake with a
// bounded wait, and parks in TRAP on illegal opcodes or memory timeouts.
// Optional build macro: MC_PERF_CNT_EN adds the 32-bit instret counter;
// without it instret is tied to 0.
module riscv_mc_sequencer #(
  parameter int WAIT_MAX = 255,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  instr_opcode,
  input  logic        br_cond,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wd_src,
  output logic [2:0]  state,
  output logic        retire,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } cls_t;

  state_t            state_q, state_d;
  cls_t              cls_q, cls_dec;
  logic [WAIT_W-1:0] wait_q;
  logic              illegal_q, bus_err_q;
  logic              mem_wait, timeout;

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  // A request cycle without completion; the count includes the current
  // cycle, so WAIT_MAX unanswered request cycles trip the timeout and a
  // mem_ready in that same cycle still completes normally.
  assign mem_wait = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
  assign timeout  = mem_wait && (wait_q == WAIT_W'(WAIT_MAX - 1));

  // Opcode classification, registered in DECODE.
  always_comb begin
    cls_dec = C_ILL;
    case (instr_opcode)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_IALU;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      7'b1101111: cls_dec = C_JAL;
      7'b1100111: cls_dec = C_JALR;
      7'b0110111: cls_dec = C_LUI;
      7'b0010111: cls_dec = C_AUIPC;
      default:    cls_dec = C_ILL;
    endcase
  end

  // Next state and strobes; idle mux selects are PC+4 and ALU result.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b10;
    reg_write = 1'b0;
    wd_src    = 2'b01;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = (cls_dec == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = br_cond ? 2'b01 : 2'b10;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          C_JAL, C_JALR: begin
            reg_write = 1'b1;
            wd_src    = 2'b00;
            pc_write  = 1'b1;
            pc_src    = (cls_q == C_JAL) ? 2'b01 : 2'b00;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wd_src    = (cls_q == C_LOAD) ? 2'b10 : 2'b01;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // State register and instruction class capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_R;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
    end
  end

  // Wait counter: counts unanswered request cycles, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_q <= '0;
    else if (mem_wait && !timeout) wait_q <= wait_q + WAIT_W'(1);
    else                         wait_q <= '0;
  end

  // Sticky fault flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q == S_DECODE && cls_dec == C_ILL) illegal_q <= 1'b1;
      if (timeout)                                 bus_err_q <= 1'b1;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] instret_q;
  assign instret = instret_q;

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// tb_riscv_mc_sequencer: randomized instruction stream checked cycle by
// cycle against a per-instruction phase model of the sequencer.
module tb_riscv_mc_sequencer;
  localparam int WM = 4;
`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_JALR = 5, K_ILL = 6;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] instr_opcode = 7'h13;
  logic br_cond = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, reg_write;
  logic retire, illegal, bus_err;
  logic [1:0] pc_src, wd_src;
  logic [2:0] state;
  logic [31:0] instret;

  int n_chk = 0, n_fail = 0, retired = 0;

  riscv_mc_sequencer #(.WAIT_MAX(WM), .WAIT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .br_cond(br_cond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wd_src(wd_src), .state(state), .retire(retire),
    .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return {15'd0, state, mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write,
            pc_src, reg_write, wd_src, retire, illegal, bus_err};
  endfunction

  function automatic logic [31:0] ev(logic [2:0] st, logic req, logic we, logic asel,
                                     logic irw, logic mdrw, logic pcw, logic [1:0] pcs,
                                     logic rw, logic [1:0] wds, logic ret, logic ill, logic be);
    return {15'd0, st, req, we, asel, irw, mdrw, pcw, pcs, rw, wds, ret, ill, be};
  endfunction

  function automatic int kind(logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return K_ALU;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      default:    return K_ILL;
    endcase
  endfunction

  // Drive one cycle's inputs mid-cycle and check the combinational outputs.
  task automatic cyc(input string tag, input logic rdy, input logic br, input logic [31:0] exp);
    @(negedge clk);
    mem_ready = rdy;
    br_cond   = br;
    #1;
    chk(tag, obs(), exp);
  endtask

  function automatic logic [31:0] trap_vec(logic ill, logic be);
    return ev(3'd7, 0, 0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 0, ill, be);
  endfunction

  // Asynchronous reset pulse mid-cycle, then release into IDLE.
  task automatic rst_pulse();
    logic [31:0] rst_v;
    rst_v = ev(3'd0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", obs(), rst_v);
    chk("rst_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_idle", obs(), rst_v);
    retired = 0;
  endtask

  // One instruction: fw/mw wait cycles before mem_ready; a wait of WM or
  // more never answers and expects the timeout trap.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic br);
    int k;
    logic last;
    k = kind(op);
    instr_opcode = op;
    if (fw >= WM) begin
      for (int i = 0; i < WM; i++) begin
        cyc("fetch_wait", 0, br, ev(3'd1, 1, 0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0));
        if (i == 0) chk("instret", instret, PERF ? retired : 0);
      end
      cyc("fetch_timeout", 0, br, trap_vec(0, 1));
      cyc("trap_hold", 1, br, trap_vec(0, 1));
      return;
    end
    for (int i = 0; i <= fw; i++) begin
      last = (i == fw);
      cyc("fetch", last, br, ev(3'd1, 1, 0, 0, last, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0));
      if (i == 0) chk("instret", instret, PERF ? retired : 0);
    end
    cyc("decode", 1'($urandom_range(0, 1)), br, ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0));
    if (k == K_ILL) begin
      for (int i = 0; i < 20; i++)
        cyc("trap_illegal", 1'($urandom_range(0, 1)), br, trap_vec(1, 0));
      return;
    end
    case (k)
      K_BR:   begin cyc("exec_br", 0, br, ev(3'd3, 0, 0, 0, 0, 0, 1, br ? 2'b01 : 2'b10, 0, 2'b01, 1, 0, 0)); retired++; end
      K_JAL:  begin cyc("exec_jal", 0, br, ev(3'd3, 0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 1, 0, 0)); retired++; end
      K_JALR: begin cyc("exec_jalr", 0, br, ev(3'd3, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1, 0, 0)); retired++; end
      default: cyc("exec", 1'($urandom_range(0, 1)), br, ev(3'd3, 0, 0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0));
    endcase
    if (k == K_LOAD || k == K_STORE) begin
      if (mw >= WM) begin
        for (int i = 0; i < WM; i++)
          cyc("mem_wait", 0, br, ev(3'd4, 1, k == K_STORE, 1, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0));
        cyc("mem_timeout", 0, br, trap_vec(0, 1));
        return;
      end
      for (int i = 0; i <= mw; i++) begin
        last = (i == mw);
        if (k == K_STORE)
          cyc("mem_store", last, br, ev(3'd4, 1, 1, 1, 0, 0, last, 2'b10, 0, 2'b01, last, 0, 0));
        else
          cyc("mem_load", last, br, ev(3'd4, 1, 0, 1, 0, last, 0, 2'b10, 0, 2'b01, 0, 0, 0));
      end
      if (k == K_STORE) retired++;
    end
    if (k == K_ALU || k == K_LOAD) begin
      cyc("wb", 1'($urandom_range(0, 1)), br,
          ev(3'd5, 0, 0, 0, 0, 0, 1, 2'b10, 1, (k == K_LOAD) ? 2'b10 : 2'b01, 1, 0, 0));
      retired++;
    end
  endtask

  logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    rst_pulse();
    // directed patterns
    run_instr(7'b0110011, 0, 0, 0);   // add
    run_instr(7'b0000011, 0, 3, 0);   // load, ready on 4th MEM cycle
    run_instr(7'b1100011, 0, 0, 1);   // taken branch
    run_instr(7'b1100011, 0, 0, 0);   // not-taken branch
    run_instr(7'b1101111, 1, 0, 0);   // jal
    run_instr(7'b1100111, 0, 0, 1);   // jalr
    run_instr(7'b0100011, 2, 1, 0);   // store
    run_instr(7'b0110111, 3, 0, 0);   // lui, ready on timeout-boundary cycle
    run_instr(7'b0010111, 1, 0, 0);   // auipc
    run_instr(7'b0010011, 0, 0, 0);   // addi
    // random mixed stream
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    // illegal opcode, then reset recovery
    run_instr(7'h7F, 0, 0, 0);
    rst_pulse();
    // fetch timeout
    run_instr(7'b0110011, WM, 0, 0);
    rst_pulse();
    // load timeout in MEM
    run_instr(7'b0000011, 0, WM, 0);
    rst_pulse();
    // reset in the middle of a store's MEM wait
    for (int n = 0; n < 3; n++) run_instr(ops[$urandom_range(0, 8)], 0, 0, 0);
    instr_opcode = 7'b0100011;
    cyc("pre_fetch", 1, 0, ev(3'd1, 1, 0, 0, 1, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0));
    chk("pre_instret", instret, PERF ? retired : 0);
    cyc("pre_decode", 0, 0, ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0));
    cyc("pre_exec", 0, 0, ev(3'd3, 0, 0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0));
    cyc("pre_mem", 0, 0, ev(3'd4, 1, 1, 1, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0));
    rst_pulse();
    run_instr(7'b0110011, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_mc_sequencer.md
# riscv_mc_sequencer

Multi-cycle control sequencer for the RISC-V datapath. It steps one RV32I instruction at a time through fetch, decode, execute, memory and write-back, and drives the same mux and strobe encodings the datapath already decodes: `pc_src`, `wd_src` and the register-write enable. It also owns the handshake to a single shared instruction/data memory port, bounds every memory wait with a timeout, and halts on illegal opcodes or bus errors.

## Interface
- `WAIT_MAX`, default 255: maximum cycles `mem_req` may stay high without `mem_ready` before a bus error.
- `WAIT_W`, default 8: width of the wait counter. Must satisfy 2^WAIT_W > WAIT_MAX.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `instr_opcode`, in, 7: instruction[6:0] from the datapath instruction register.
- `br_cond`, in, 1: branch condition from the ALU Z flag, valid in EXEC.
- `mem_ready`, in, 1: memory completes the current request this cycle.
- `mem_req`, out, 1: memory request, held until `mem_ready`.
- `mem_we`, out, 1: request is a store.
- `addr_sel`, out, 1: 0 selects PC as the memory address; 1 selects the ALU result.
- `ir_write`, out, 1: latch the instruction register.
- `mdr_write`, out, 1: latch the memory data register.
- `pc_write`, out, 1: update PC.
- `pc_src`, out, 2: 10 = PC+4, 01 = branch/JAL target, 00 = JALR target.
- `reg_write`, out, 1: register file write enable.
- `wd_src`, out, 2: 00 = PC+4, 01 = ALU result, 10 = memory data.
- `state`, out, 3: current state encoding.
- `retire`, out, 1: one-cycle pulse per completed instruction.
- `illegal`, out, 1: sticky flag for an illegal opcode.
- `bus_err`, out, 1: sticky flag for a memory timeout.
- `instret`, out, 32: retired-instruction count (see Configuration).

## Operation
- **State encoding:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- **Reset:** `rst_n` low forces IDLE asynchronously.
  - Every output resets to 0, except `pc_src`=10 and `wd_src`=01.
  - An in-flight request is abandoned and `mem_req` drops with reset.
- **IDLE:** moves to FETCH on the next cycle, unconditionally.
- **FETCH:**
  - Drives `mem_req`=1, `addr_sel`=0, `mem_we`=0.
  - On `mem_ready`: `ir_write`=1 in the same cycle, then go to DECODE.
- **DECODE:**
  - Classifies `instr_opcode` and registers the class: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode sets `illegal` and goes to TRAP. All other classes go to EXEC.
- **EXEC:**
  - BRANCH: `pc_write`=1, `pc_src` = `br_cond` ? 01 : 10, `retire`, go to FETCH.
  - JAL/JALR: `reg_write`=1, `wd_src`=00, `pc_write`=1, `pc_src`=01 for JAL or 00 for JALR, `retire`, go to FETCH.
  - LOAD/STORE: go to MEM.
  - R, I-ALU, LUI, AUIPC: go to WB.
- **MEM:**
  - Drives `mem_req`=1, `addr_sel`=1, `mem_we`=1 for STORE.
  - On `mem_ready` for STORE: `pc_write`=1, `pc_src`=10, `retire`, go to FETCH.
  - On `mem_ready` for LOAD: `mdr_write`=1, go to WB.
- **WB:**
  - `reg_write`=1, `wd_src` = LOAD ? 10 : 01.
  - `pc_write`=1, `pc_src`=10, `retire`, go to FETCH.
- **TRAP:**
  - All strobes stay 0 and the block stays in TRAP until reset.
  - `illegal` and `bus_err` hold their value.
- **Wait counter:**
  - Cleared on entry to FETCH or MEM and incremented each cycle `mem_req` is high without `mem_ready`.
  - When the count equals WAIT_MAX and `mem_ready` is still low: set `bus_err`, drop `mem_req` on the next cycle, go to TRAP.
  - If `mem_ready` arrives in the same cycle the count reaches WAIT_MAX, `mem_ready` wins.
- **`mem_ready` outside FETCH/MEM:** ignored.

## Timing
- All state and flags are registered.
- Strobes are combinational from the state, the registered class, `mem_ready` and `br_cond`. Datapath registers capture on the same edge.
- Cycle counts with zero-wait memory (`mem_ready` in the first request cycle):
  - Branch/JAL/JALR: 3 cycles.
  - ALU/LUI/AUIPC: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle adds one cycle.
- `mem_req`, `mem_we` and `addr_sel` stay stable from assertion through the `mem_ready` cycle.
- Exactly one `retire` pulse and exactly one `pc_write` per instruction, both in the final cycle of that instruction.
- First fetch request: the second rising edge after `rst_n` deasserts.

## Configuration
- **`MC_PERF_CNT_EN` defined:**
  - `instret` is a 32-bit counter incremented on each `retire`, reset to 0, wrapping from 0xFFFFFFFF to 0.
- **`MC_PERF_CNT_EN` undefined:**
  - No counter logic is built.
  - `instret` is tied to 0.

## Test plan
- **Zero-wait `add` (opcode 0110011):** states go 1→2→3→5→1. `reg_write`=1 with `wd_src`=01 in WB. `retire` at cycle 4 of the instruction.
- **Load 0000011 with `mem_ready` delayed 3 cycles in MEM:** `mdr_write` pulses once, then WB drives `wd_src`=10. Total of 8 cycles.
- **Branch 1100011:** with `br_cond`=1, EXEC drives `pc_src`=01; with `br_cond`=0, `pc_src`=10. Both retire after 3 cycles.
- **Opcode 1111111:** `illegal`=1 after DECODE, `state`=7, all strobes 0 for 20 cycles. `rst_n` pulse clears it and returns to IDLE.
- **WAIT_MAX=4, `mem_ready` held 0 in FETCH:** `bus_err`=1 after 4 waiting cycles, `mem_req` drops, `state`=7. A second run with `mem_ready` on the 4th cycle completes normally.
- **`MC_PERF_CNT_EN` defined, 10 mixed instructions:** `instret`=10. `rst_n` asserted mid-MEM drops `mem_req` immediately and `instret`=0.
